// File: rtl/karatsuba_pkg.sv
// karatsuba_pkg: constants and types shared by the dot-product accumulator
// wrapped around the external 16x16 approximate Karatsuba multiplier.
//   N         operand width
//   PROD_W    product word width (2*N)
//   ACC_W_DEF default accumulator / result width
//   dot_state_t  frame-sequencing FSM encoding
//   prod_t       product word
package karatsuba_pkg;

    localparam int N         = 16;
    localparam int PROD_W    = 2 * N;
    localparam int ACC_W_DEF = 40;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } dot_state_t;

    typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/karatsuba_dot_acc_core.sv
// dot_acc_core: product register (S2), accumulator, sticky carry-out and
// saturating beat counter for one dot-product path.
//   clk, rst        clock, synchronous active-high reset
//   s1_valid/last   beat currently on the multiplier inputs
//   prod            product for that beat
//   fin             final beat of the frame is accumulating this cycle
//   sum_next        acc + p_reg (modulo 2^ACC_W)
//   cnt_next        cnt + 1, saturating at all-ones
//   ovf_next        sticky overflow including this cycle's carry
// The frame totals are exposed combinationally so the owner can latch them
// in the same cycle the core clears itself for the next frame.
module dot_acc_core #(
    parameter int P_W   = 32,
    parameter int ACC_W = 40,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1_valid,
    input  logic             s1_last,
    input  logic [P_W-1:0]   prod,
    output logic             fin,
    output logic [ACC_W-1:0] sum_next,
    output logic [CNT_W-1:0] cnt_next,
    output logic             ovf_next
);

    logic [P_W-1:0]   p_reg;
    logic             s2_valid;
    logic             s2_last;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [ACC_W:0]   sum_wide;

    // one extra bit on top of the accumulator captures the carry-out
    assign sum_wide = {1'b0, acc} + {{(ACC_W + 1 - P_W){1'b0}}, p_reg};
    assign sum_next = sum_wide[ACC_W-1:0];
    assign ovf_next = ovf | sum_wide[ACC_W];
    assign cnt_next = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign fin      = s2_valid & s2_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg    <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) begin
                p_reg <= prod;
            end
            if (s2_valid) begin
                if (s2_last) begin
                    acc <= '0;
                    cnt <= '0;
                    ovf <= 1'b0;
                end else begin
                    acc <= sum_next;
                    cnt <= cnt_next;
                    ovf <= ovf_next;
                end
            end
        end
    end

endmodule

// File: rtl/karatsuba_dot_acc.sv
// karatsuba_dot_acc: sequential wrapper around the external combinational
// 16x16 approximate Karatsuba multiplier. Takes a valid/ready stream of
// unsigned operand pairs, registers them onto mul_a/mul_b, accumulates the
// returned products and emits one sum per frame (frame ends on in_last).
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b/in_last   operand stream
//   mul_a, mul_b (out), mul_p (in)        multiplier connection
//   out_valid/out_ready           result handshake
//   out_sum, out_cnt, out_ovf     frame sum, beat count, sticky carry-out
//   out_err                       exact minus approximate sum (signed)
// Build option: KARATSUBA_DOT_EXACT_REF_EN adds an exact product path and
// drives out_err; otherwise out_err is constant zero.
//
// state | meaning
// RUN   | accepting beats
// DRAIN | last beat accepted, waiting for it to reach the accumulator
// HOLD  | result presented, waiting for out_ready
module karatsuba_dot_acc
    import karatsuba_pkg::*;
#(
    parameter int N     = 16,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_last,
    output logic [N-1:0]     mul_a,
    output logic [N-1:0]     mul_b,
    input  logic [2*N-1:0]   mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf,
    output logic [ACC_W:0]   out_err
);

    localparam int P_W = 2 * N;

    dot_state_t       state;
    logic             in_ready_r;
    logic             accept;
    logic             s1_valid;
    logic             s1_last;
    logic             fin;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    // in_ready_r comes out of reset set, so the gate makes in_ready low
    // while rst is held and high in the very first cycle after release
    assign in_ready = in_ready_r & ~rst;
    assign accept   = in_valid & in_ready;

    dot_acc_core #(
        .P_W   (P_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .s1_valid (s1_valid),
        .s1_last  (s1_last),
        .prod     (mul_p),
        .fin      (fin),
        .sum_next (sum_next),
        .cnt_next (cnt_next),
        .ovf_next (ovf_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            in_ready_r <= 1'b1;
            mul_a      <= '0;
            mul_b      <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_cnt    <= '0;
            out_ovf    <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_last  <= accept & in_last;
            if (accept) begin
                mul_a <= in_a;
                mul_b <= in_b;
            end
            case (state)
                ST_RUN: begin
                    if (accept && in_last) begin
                        in_ready_r <= 1'b0;
                        state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fin) begin
                        out_sum   <= sum_next;
                        out_cnt   <= cnt_next;
                        out_ovf   <= ovf_next;
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        in_ready_r <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                default: begin
                    out_valid  <= 1'b0;
                    in_ready_r <= 1'b1;
                    state      <= ST_RUN;
                end
            endcase
        end
    end

`ifdef KARATSUBA_DOT_EXACT_REF_EN
    logic [P_W-1:0]   exact_p;
    logic             x_fin;
    logic [ACC_W-1:0] x_sum;
    logic [CNT_W-1:0] x_cnt;
    logic             x_ovf;
    logic             unused_exact;

    assign exact_p = P_W'(mul_a) * P_W'(mul_b);

    // the exact path shares the beat sequencing; only its sum is consumed
    dot_acc_core #(
        .P_W   (P_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_exact (
        .clk      (clk),
        .rst      (rst),
        .s1_valid (s1_valid),
        .s1_last  (s1_last),
        .prod     (exact_p),
        .fin      (x_fin),
        .sum_next (x_sum),
        .cnt_next (x_cnt),
        .ovf_next (x_ovf)
    );

    assign unused_exact = ^{x_fin, x_cnt, x_ovf};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_err <= '0;
        end else if (state == ST_DRAIN && fin) begin
            out_err <= {1'b0, x_sum} - {1'b0, sum_next};
        end
    end
`else
    assign out_err = '0;
`endif

endmodule

// File: tb/tb_karatsuba_dot_acc.sv
`timescale 1ns/1ps
module tb_karatsuba_dot_acc;
    import karatsuba_pkg::*;

    localparam int TN   = 16;
    localparam int TACC = 33;
    localparam int TCNT = 10;
`ifdef KARATSUBA_DOT_EXACT_REF_EN
    localparam logic [TACC:0] ERR5 = 34'd5;
`else
    localparam logic [TACC:0] ERR5 = 34'd0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [TN-1:0]   in_a;
    logic [TN-1:0]   in_b;
    logic            in_last;
    logic [TN-1:0]   mul_a;
    logic [TN-1:0]   mul_b;
    prod_t           mul_p;
    logic            out_valid;
    logic            out_ready;
    logic [TACC-1:0] out_sum;
    logic [TCNT-1:0] out_cnt;
    logic            out_ovf;
    logic [TACC:0]   out_err;
    logic            approx_off = 1'b0;

    typedef struct packed {
        logic [TACC-1:0] sum;
        logic [TCNT-1:0] cnt;
        logic            ovf;
        logic [TACC:0]   err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    int   acc_cyc = 0;
    logic ov_prev = 1'b0;
    logic [TN-1:0] va [0:1099];
    logic [TN-1:0] vb [0:1099];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // behavioural multiplier: exact, or exact-1 when approx_off is set
    assign mul_p = prod_t'(mul_a) * prod_t'(mul_b) - prod_t'(approx_off);

    karatsuba_dot_acc #(.N(TN), .ACC_W(TACC), .CNT_W(TCNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [TACC-1:0] s, input logic [TCNT-1:0] c,
                            input logic o, input logic [TACC:0] e);
        exp_t x;
        x.sum = s; x.cnt = c; x.ovf = o; x.err = e;
        exp_q.push_back(x);
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send_beat(input logic [TN-1:0] a, input logic [TN-1:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        if (last) last_acc_cyc = cyc;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            send_beat(va[i], vb[i], (i == n - 1));
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    // monitor: samples 2 ns after the negedge, pops on each result handshake
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            if (out_valid && !ov_prev) chk("latency_edges", 64'(cyc - last_acc_cyc), 64'd2);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_result: got sum 0x%0h cnt %0d, required none", out_sum, out_cnt);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_sum", 64'(out_sum), 64'(e.sum));
                    chk("out_cnt", 64'(out_cnt), 64'(e.cnt));
                    chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
                    chk("out_err", 64'(out_err), 64'(e.err));
                end
            end
        end
        ov_prev = out_valid;
    end

    initial begin
        int h;
        // reset with a beat presented: nothing may be accepted or produced
        rst = 1'b1; in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h5678; in_last = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mul_ab", 64'({mul_a, mul_b}), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_cnt_ovf", 64'({out_cnt, out_ovf}), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);
        repeat (4) @(negedge clk);

        // 4-beat frame: 15 + 77 + 65535 + 4 = 65631
        va[0] = 3; vb[0] = 5; va[1] = 7; vb[1] = 11;
        va[2] = 16'hFFFF; vb[2] = 1; va[3] = 2; vb[3] = 2;
        push_exp(33'h1005F, 10'd4, 1'b0, '0);
        send_frame(4);
        drain();

        // single-beat frame
        push_exp(33'hFFFE0001, 10'd1, 1'b0, '0);
        send_beat(16'hFFFF, 16'hFFFF, 1'b1);
        drain();

        // backpressure in HOLD: 9 + 16 = 25
        out_ready = 1'b0;
        va[0] = 3; vb[0] = 3; va[1] = 4; vb[1] = 4;
        push_exp(33'd25, 10'd2, 1'b0, '0);
        send_frame(2);
        wait_valid();
        in_valid = 1'b1; in_a = 16'd7; in_b = 16'd7; in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_sum", 64'(out_sum), 64'd25);
        end
        out_ready = 1'b1;
        h = cyc;
        push_exp(33'd49, 10'd1, 1'b0, '0);
        send_beat(16'd7, 16'd7, 1'b1);
        chk("accept_after_release", 64'(acc_cyc - h), 64'd2);
        drain();

        // reset while holding a result: the result is discarded
        out_ready = 1'b0;
        send_beat(16'd1, 16'd1, 1'b0);
        send_beat(16'd2, 16'd2, 1'b1);
        wait_valid();
        rst = 1'b1;
        @(negedge clk);
        chk("hold_rst_out_valid", 64'(out_valid), 64'd0);
        chk("hold_rst_out_sum", 64'(out_sum), 64'd0);
        rst = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // reset mid-frame: partial beats discarded; next frame 6 + 20 = 26
        send_beat(16'd5, 16'd5, 1'b0);
        send_beat(16'd6, 16'd6, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        va[0] = 2; vb[0] = 3; va[1] = 4; vb[1] = 5;
        push_exp(33'd26, 10'd2, 1'b0, '0);
        send_frame(2);
        drain();

        // overflow: 3 * 0xFFFE0001 = 0x2FFFA0003, mod 2^33 = 0x0FFFA0003
        for (int i = 0; i < 3; i++) begin va[i] = 16'hFFFF; vb[i] = 16'hFFFF; end
        push_exp(33'h0FFFA0003, 10'd3, 1'b1, '0);
        send_frame(3);
        drain();

        // approximate products (exact - 1): exact 141283, approx 141278
        approx_off = 1'b1;
        va[0] = 10; vb[0] = 20; va[1] = 3; vb[1] = 4; va[2] = 100; vb[2] = 100;
        va[3] = 1; vb[3] = 1; va[4] = 16'hFFFF; vb[4] = 2;
        push_exp(33'd141278, 10'd5, 1'b0, ERR5);
        send_frame(5);
        drain();
        approx_off = 1'b0;

        // counter saturation: 1025 beats of 1x1
        for (int i = 0; i < 1025; i++) begin va[i] = 1; vb[i] = 1; end
        push_exp(33'd1025, 10'd1023, 1'b0, '0);
        send_frame(1025);
        drain();

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
